// File: rtl/interpol_slope.sv
// interpol_slope: paces slow-rate samples into first differences and
// pre-scaled phase steps for the downstream interpolator, released on a
// fixed-period strobe. A missing sample at strobe time yields a zero step
// and raises a sticky underrun flag.
module interpol_slope #(
    parameter int unsigned cntw   = 7,
    parameter int unsigned period = 112,
    parameter int unsigned scale  = 18725
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic        clr_err,
    output logic        strobe,
    output logic [16:0] dy,
    output logic [17:0] dy7,
    output logic        underrun
);

    localparam int unsigned XW = 16;
    localparam int unsigned DW = 17;
    localparam int unsigned QW = 18;
    localparam int unsigned SW = 16;
    localparam int unsigned PW = 33;
    localparam int unsigned RS = 14;

    // period < 2^cntw, so the tick counter fits in cntw bits
    localparam logic [cntw-1:0]      CNT_LOAD = cntw'(period - 1);
    localparam logic [SW-1:0]        SCALE_W  = SW'(scale);
    localparam logic signed [PW-1:0] RND      = PW'(1 << (RS - 1));
    localparam logic signed [PW-1:0] QMAX     = PW'((1 << (QW - 1)) - 1);
    localparam logic signed [PW-1:0] QMIN     = -QMAX - PW'(1);

    logic [cntw-1:0]        cnt_q, cnt_d;
    logic                   tick;
    logic                   primed_q, primed_d;
    logic signed [XW-1:0]   xprev_q, xprev_d;
    logic signed [XW-1:0]   x0_q, x0_d;
    logic                   v0_q, v0_d;
    logic signed [DW-1:0]   d1_q, d1_d;
    logic                   v1_q, v1_d;
    logic signed [DW-1:0]   d2_q, d2_d;
    logic signed [PW-1:0]   p2_q, p2_d;
    logic                   v2_q, v2_d;
    logic signed [DW-1:0]   dyp_q, dyp_d;
    logic signed [QW-1:0]   dy7p_q, dy7p_d;
    logic                   full_q, full_d;
    logic                   strobe_q, strobe_d;
    logic signed [DW-1:0]   dy_q, dy_d;
    logic signed [QW-1:0]   dy7_q, dy7_d;
    logic                   underrun_q, underrun_d;

    logic                   busy;
    logic                   accept;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   rnd;
    logic signed [QW-1:0]   q_sat;

    // Ready depends on state only: no sample while one is in flight or pending
    assign busy     = v0_q | v1_q | v2_q;
    assign x_ready  = ~full_q & ~busy;
    assign accept   = x_valid & x_ready;

    assign strobe   = strobe_q;
    assign dy       = dy_q;
    assign dy7      = dy7_q;
    assign underrun = underrun_q;

    // Scale, round-half-up and saturate the difference to the 18-bit step range
    always_comb begin
        prod  = PW'(d1_q) * $signed(PW'(SCALE_W));
        rnd   = (p2_q + RND) >>> RS;
        q_sat = QW'(rnd);
        if (rnd > QMAX) begin
            q_sat = QW'(QMAX);
        end else if (rnd < QMIN) begin
            q_sat = QW'(QMIN);
        end
    end

    // Next-state: free-running tick, priming, 3-stage pipeline, strobe release
    always_comb begin
        cnt_d      = cnt_q - cntw'(1);
        tick       = (cnt_q == '0);
        primed_d   = primed_q;
        xprev_d    = xprev_q;
        x0_d       = x0_q;
        v0_d       = 1'b0;
        d1_d       = d1_q;
        v1_d       = v0_q;
        d2_d       = d2_q;
        p2_d       = p2_q;
        v2_d       = v1_q;
        dyp_d      = dyp_q;
        dy7p_d     = dy7p_q;
        full_d     = full_q;
        strobe_d   = 1'b0;
        dy_d       = dy_q;
        dy7_d      = dy7_q;
        underrun_d = clr_err ? 1'b0 : underrun_q;

        if (tick) begin
            cnt_d = CNT_LOAD;
        end

        // first sample after reset only establishes the reference
        if (accept) begin
            if (primed_q) begin
                x0_d = $signed(x);
                v0_d = 1'b1;
            end else begin
                xprev_d  = $signed(x);
                primed_d = 1'b1;
            end
        end

        if (v0_q) begin
            d1_d    = DW'(x0_q) - DW'(xprev_q);
            xprev_d = x0_q;
        end

        if (v1_q) begin
            d2_d = d1_q;
            p2_d = prod;
        end

        // tick sees the pre-update full flag; a same-cycle S3 stays pending
        if (tick) begin
            strobe_d = 1'b1;
            if (full_q) begin
                dy_d   = dyp_q;
                dy7_d  = dy7p_q;
                full_d = 1'b0;
            end else begin
                dy_d       = '0;
                dy7_d      = '0;
                underrun_d = 1'b1;
            end
        end

        if (v2_q) begin
            dyp_d  = d2_q;
            dy7p_d = q_sat;
            full_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= CNT_LOAD;
            primed_q   <= 1'b0;
            xprev_q    <= '0;
            x0_q       <= '0;
            v0_q       <= 1'b0;
            d1_q       <= '0;
            v1_q       <= 1'b0;
            d2_q       <= '0;
            p2_q       <= '0;
            v2_q       <= 1'b0;
            dyp_q      <= '0;
            dy7p_q     <= '0;
            full_q     <= 1'b0;
            strobe_q   <= 1'b0;
            dy_q       <= '0;
            dy7_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            xprev_q    <= xprev_d;
            x0_q       <= x0_d;
            v0_q       <= v0_d;
            d1_q       <= d1_d;
            v1_q       <= v1_d;
            d2_q       <= d2_d;
            p2_q       <= p2_d;
            v2_q       <= v2_d;
            dyp_q      <= dyp_d;
            dy7p_q     <= dy7p_d;
            full_q     <= full_d;
            strobe_q   <= strobe_d;
            dy_q       <= dy_d;
            dy7_q      <= dy7_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
